alu_multicycle: RTL
===================

# alu_multicycle

Parametrised successor to the single-cycle RV32I ALU. It executes the base integer op set on XLEN-bit operands and adds the RISC-V M-extension multiply/divide ops through an iterative datapath. Operands enter and results leave through valid/ready handshakes, so the CPU stalls only while a multi-cycle op is in flight. It sits between the decode/register-read stage and writeback.

## Interface
- XLEN, 32: operand/result width; power of two, 8..64
- SHAMT_W, $clog2(XLEN): shift-amount width (localparam)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation
- reg_source1  in  XLEN  rs1 operand
- reg_source2  in  XLEN  rs2 operand
- imm_source  in  XLEN  sign-extended immediate
- imm  in  1  use imm_source instead of reg_source2
- funct3  in  3  operation select
- funct7  in  7  0x00 base, 0x20 SUB/SRA, 0x01 M-extension
- out_valid  out  1  res holds a result
- out_ready  in  1  consumer takes result
- res  out  XLEN  result
- busy  out  1  multi-cycle op in progress

## Operation
- Clocking: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Accept: in_valid && in_ready at a rising edge. Operands, imm, funct3 and funct7 are captured; inputs are don't-care afterwards.
- src2 = imm ? imm_source : reg_source2.
- Base ops (funct7 != 0x01, or imm=1):
  - ADD/SUB: SUB only when funct7=0x20 and imm=0.
  - SLL/SRL/SRA: shift by src2[SHAMT_W-1:0] only. SRA is a true arithmetic shift, selected by funct7=0x20.
  - SLT: signed compare. SLTU: unsigned compare. Result is zero-extended 0/1.
  - XOR, OR, AND.
- M ops (funct7=0x01, imm=0; funct3 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU):
  - Multiply: radix-2 shift-add on magnitudes over a 2·XLEN product, with sign correction at the end.
  - Divide: restoring division on magnitudes; quotient and remainder signs follow RISC-V rules.
- Special cases, resolved in one cycle with no iteration:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - DIV of the most negative value by −1 → most negative value; the matching REM → 0.
- FSM states:
  - IDLE: accept → ITER (M op, non-special) or DONE (all other ops).
  - ITER: the counter runs XLEN cycles, then → DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, or accept a new op in the same cycle (see in_ready).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- busy = (state==ITER).
- Reset values: state IDLE, out_valid 0, res 0, busy 0, in_ready 1, counter 0.
- Reset mid-operation aborts the op and discards it. There is no other flush.

## Timing
- Base op or special-case M op accepted at edge N → out_valid at N+1.
- Non-special M op accepted at edge N → out_valid at N+XLEN+1.
- res and out_valid are registered and held stable while out_valid && !out_ready.
- Back-to-back base ops with out_ready tied high: one result per cycle.
- The iteration counter is SHAMT_W+1 bits and saturates; it is cleared on accept.

## Configuration
- ALU_MDU_EN defined: M ops are implemented as described above.
- ALU_MDU_EN undefined: the iterative datapath and the ITER state are not compiled in. funct7=0x01 decodes as funct7=0x00, giving the base op for that funct3 with 1-cycle latency. busy is tied to 0.

## Structure
- Package alu_pkg holds:
  - funct3 constants (F3_ADD…F3_AND, F3_MUL…F3_REMU)
  - funct7 constants (F7_BASE=0x00, F7_ALT=0x20, F7_MULDIV=0x01)
  - the FSM state enum (IDLE, ITER, DONE)
- Sub-module alu_mdu contains the iterative multiply/divide datapath and counter, with a start/done pair. It is instantiated only under ALU_MDU_EN.

## Test plan
- Base ops: SUB 5−7 → 0xFFFFFFFE; SRA 0x80000000 by 4 → 0xF8000000; SLL by rs2=33 → shift by 1; SLTU 1 vs 0xFFFFFFFF → 1. All complete with 1-cycle latency.
- MULH −2 × 3 → 0xFFFFFFFF and MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. out_valid rises exactly 33 cycles after accept.
- Division special cases:
  - DIV 7 / 0 → 0xFFFFFFFF; REMU 7 / 0 → 7.
  - DIV 0x80000000 / −1 → 0x80000000; REM of the same operands → 0.
  - All four complete in 1 cycle.
- Backpressure: out_ready held low for 5 cycles after a DIVU 100/7 result. res stays 14 and in_ready stays 0 until out_ready rises; a new ADD is then accepted in that same cycle.
- Pull rst_n low 10 cycles into a MUL → out_valid, busy and res go to 0 immediately. After release, in_ready=1 and the next ADD 2+2 → 4.
- Build without ALU_MDU_EN: funct7=0x01, funct3=0 on 3, 4 → 7 in 1 cycle, and busy never asserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: funct3/funct7 decode values and FSM states.
// Used by alu_multicycle and by alu_mdu, which is present only when ALU_MDU_EN is defined.
package alu_pkg;

  localparam logic [2:0] F3_ADD    = 3'd0;
  localparam logic [2:0] F3_SLL    = 3'd1;
  localparam logic [2:0] F3_SLT    = 3'd2;
  localparam logic [2:0] F3_SLTU   = 3'd3;
  localparam logic [2:0] F3_XOR    = 3'd4;
  localparam logic [2:0] F3_SRL    = 3'd5;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mdu.sv
// Iterative M-extension datapath: radix-2 shift-add multiply and restoring divide on magnitudes.
// Only instantiated when ALU_MDU_EN is defined. Divide-by-zero and overflow never reach this unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  logic [2:0]      op_q;
  logic            negQ_q, negR_q, active_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] opnd_q, hi_q, lo_q, hi_d, lo_d;

  logic            isDiv, aSigned, bSigned, aNeg, bNeg;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN:0]   mulSum, remShift, remDiff;
  logic [2*XLEN-1:0] prod, prodFix;
  logic [XLEN-1:0] quo, rem;

  // Operand magnitudes and the sign corrections to apply once iteration finishes.
  always_comb begin
    isDiv   = funct3_i[2];
    aSigned = isDiv ? ~funct3_i[0] : (funct3_i != F3_MULHU);
    bSigned = isDiv ? ~funct3_i[0] : ~funct3_i[1];
    aNeg    = aSigned & a_i[XLEN-1];
    bNeg    = bSigned & b_i[XLEN-1];
    magA    = aNeg ? -a_i : a_i;
    magB    = bNeg ? -b_i : b_i;
  end

  // hi/lo hold the running product for multiply, or remainder/quotient for divide.
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    remShift = {hi_q, lo_q[XLEN-1]};
    remDiff  = remShift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!remDiff[XLEN]) begin
        hi_d = remDiff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = remShift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {mulSum, lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (start_i) begin
      op_q     <= funct3_i;
      negQ_q   <= aNeg ^ bNeg;
      negR_q   <= aNeg;
      active_q <= 1'b1;
      cnt_q    <= '0;
      opnd_q   <= isDiv ? magB : magA;
      lo_q     <= isDiv ? magA : magB;
      hi_q     <= '0;
    end else if (active_q) begin
      if (cnt_q != LAST) begin
        cnt_q <= cnt_q + CNT_W'(1);
        hi_q  <= hi_d;
        lo_q  <= lo_d;
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  always_comb begin
    prod    = {hi_q, lo_q};
    prodFix = negQ_q ? -prod : prod;
    quo     = negQ_q ? -lo_q : lo_q;
    rem     = negR_q ? -hi_q : hi_q;
    unique case (op_q)
      F3_MUL:                      res_o = prodFix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_o = prodFix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             res_o = quo;
      default:                     res_o = rem;
    endcase
  end

  assign done_o = active_q && (cnt_q == LAST);

endmodule

// File: rtl/alu_multicycle.sv
// RV32I-style ALU with valid/ready handshakes; M-extension ops run through alu_mdu.
// Define ALU_MDU_EN to build the multiply/divide path; otherwise funct7=0x01 decodes as base.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] reg_source1,
  input  logic [XLEN-1:0] reg_source2,
  input  logic [XLEN-1:0] imm_source,
  input  logic            imm,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            accept, isSub, isAlt;
  logic [XLEN-1:0] src2, baseRes;
  logic [SHAMT_W-1:0] shamt;

  assign accept = in_valid && in_ready;

  always_comb begin
    src2    = imm ? imm_source : reg_source2;
    shamt   = src2[SHAMT_W-1:0];
    isSub   = (funct7 == F7_ALT) && !imm;
    isAlt   = (funct7 == F7_ALT);
    baseRes = '0;
    unique case (funct3)
      F3_ADD:  baseRes = isSub ? reg_source1 - src2 : reg_source1 + src2;
      F3_SLL:  baseRes = reg_source1 << shamt;
      F3_SLT:  baseRes = {{(XLEN-1){1'b0}}, $signed(reg_source1) < $signed(src2)};
      F3_SLTU: baseRes = {{(XLEN-1){1'b0}}, reg_source1 < src2};
      F3_XOR:  baseRes = reg_source1 ^ src2;
      F3_SRL:  baseRes = isAlt ? $unsigned($signed(reg_source1) >>> shamt) : reg_source1 >> shamt;
      F3_OR:   baseRes = reg_source1 | src2;
      default: baseRes = reg_source1 & src2;
    endcase
  end

`ifdef ALU_MDU_EN
  logic            isM, isSpecial, mduStart, mduDone;
  logic [XLEN-1:0] specialRes, mduRes;

  // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
  always_comb begin
    isM        = (funct7 == F7_MULDIV) && !imm;
    isSpecial  = 1'b0;
    specialRes = '0;
    if (funct3[2]) begin
      if (reg_source2 == '0) begin
        isSpecial  = 1'b1;
        specialRes = funct3[1] ? reg_source1 : '1;
      end else if (!funct3[0] && reg_source1 == MIN_VAL && reg_source2 == '1) begin
        isSpecial  = 1'b1;
        specialRes = funct3[1] ? '0 : MIN_VAL;
      end
    end
  end

  assign mduStart = accept && isM && !isSpecial;

  alu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mduStart),
    .funct3_i (funct3),
    .a_i      (reg_source1),
    .b_i      (reg_source2),
    .done_o   (mduDone),
    .res_o    (mduRes)
  );
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    if (accept) begin
`ifdef ALU_MDU_EN
      if (isM && !isSpecial) begin
        state_d = ITER;
      end else begin
        state_d = DONE;
        res_d   = isM ? specialRes : baseRes;
      end
`else
      state_d = DONE;
      res_d   = baseRes;
`endif
    end else begin
      case (state_q)
        DONE: if (out_ready) state_d = IDLE;
`ifdef ALU_MDU_EN
        ITER: if (mduDone) begin
          state_d = DONE;
          res_d   = mduRes;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
`ifdef ALU_MDU_EN
  assign busy = (state_q == ITER);
`else
  assign busy = 1'b0;
`endif

endmodule
